// File: rtl/gray2bin_drain.sv
// -----------------------------------------------------------------------------
// gray2bin_drain
//
// Bus-master reader for the register-mapped gray-code FIFO. It polls the
// CTL_STAT register, pops gray-coded words from the data register, decodes
// them to binary and hands them downstream on a valid/ready stream. This block
// is the only initiator on the FIFO register port.
//
// Optional feature macro: GRAY2BIN_AUTOCLEAR_EN
//   defined   : an overflow/underflow seen while polling triggers a one-cycle
//               write of the clear bit to CTL_STAT before any further pop.
//   undefined : no clear state; write/wdata are tied low and the error bits
//               are only recorded in err_flags.
//
// Parameters:
//   POLL_GAP  idle cycles between two polls that found the FIFO empty (1..255)
//   CNT_W     width of drained_cnt
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   go              draining enabled while high
//   enable          bus transaction active
//   addr            register address: 0 = FIFO data, 3 = CTL_STAT
//   write, read     bus strobes
//   wdata           write data (non-zero only while clearing)
//   rdata           read data, combinational on addr
//   resp            slave error response
//   bin_data        decoded binary word
//   bin_valid       bin_data valid
//   bin_ready       consumer accepts the word
//   err_flags       sticky: [0] overflow, [1] underflow, [2] resp seen
//   drained_cnt     words handed off, wraps
//   state_dbg       current FSM state encoding (debug observation)
//
// Output stream handshake: a word transfers on a rising edge where bin_valid
// and bin_ready are both high. Once bin_valid rises, bin_data holds and
// bin_valid stays high until that transfer; bin_valid never depends on
// bin_ready in the same cycle.
//
// state_dbg encoding: 0 IDLE, 1 POLL, 2 CLEAR, 3 GAP, 4 RD, 5 CAP, 6 OUT.
// -----------------------------------------------------------------------------
module gray2bin_drain #(
  parameter int POLL_GAP = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  output logic             enable,
  output logic [1:0]       addr,
  output logic             write,
  output logic             read,
  output logic [7:0]       wdata,
  input  logic [7:0]       rdata,
  input  logic             resp,
  output logic [7:0]       bin_data,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic [2:0]       err_flags,
  output logic [CNT_W-1:0] drained_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POLL  = 3'd1,
    S_GAP   = 3'd3,
    S_RD    = 3'd4,
    S_CAP   = 3'd5,
    S_OUT   = 3'd6
`ifdef GRAY2BIN_AUTOCLEAR_EN
    ,
    S_CLEAR = 3'd2
`endif
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd3;
  localparam logic [7:0] GAP_LAST  = 8'(POLL_GAP - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] gap_cnt;
  logic [7:0] gray_q;

  // CTL_STAT fields as seen during a poll.
  logic st_empty;
  logic st_ovf;
  logic st_udf;
  assign st_empty = rdata[0];
  assign st_ovf   = rdata[2];
  assign st_udf   = rdata[3];

  // The full bit and the write-only clear bit carry no meaning for a reader.
  logic unused_status;
  assign unused_status = ^{rdata[7:4], rdata[1]};

  assign state_dbg = state_q;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign bin_data = gray_to_bin(gray_q);

  // Next-state logic. Once a pop (RD) or a clear has started, it always runs
  // to completion; go is only consulted at the points where a sequence ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (go) state_d = S_POLL;
      S_POLL: begin
        if (!go) state_d = S_IDLE;
`ifdef GRAY2BIN_AUTOCLEAR_EN
        else if (st_ovf || st_udf) state_d = S_CLEAR;
`endif
        else if (st_empty) state_d = S_GAP;
        else state_d = S_RD;
      end
`ifdef GRAY2BIN_AUTOCLEAR_EN
      S_CLEAR: state_d = go ? S_POLL : S_IDLE;
`endif
      S_GAP: if (gap_cnt == GAP_LAST) state_d = go ? S_POLL : S_IDLE;
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = S_OUT;
      S_OUT: if (bin_ready) state_d = go ? S_POLL : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered bus/stream outputs (decoded from the next state so they
  // line up with the state they describe), capture registers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_cnt     <= 8'd0;
      gray_q      <= 8'd0;
      enable      <= 1'b0;
      read        <= 1'b0;
      addr        <= 2'd0;
      bin_valid   <= 1'b0;
      err_flags   <= 3'b000;
      drained_cnt <= '0;
`ifdef GRAY2BIN_AUTOCLEAR_EN
      write       <= 1'b0;
      wdata       <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      read      <= (state_d == S_POLL) || (state_d == S_RD);
      bin_valid <= (state_d == S_OUT);
`ifdef GRAY2BIN_AUTOCLEAR_EN
      enable    <= (state_d inside {S_POLL, S_CLEAR, S_RD, S_CAP});
      addr      <= (state_d inside {S_POLL, S_CLEAR}) ? ADDR_STAT : ADDR_DATA;
      write     <= (state_d == S_CLEAR);
      wdata     <= (state_d == S_CLEAR) ? 8'h10 : 8'h00;
`else
      enable    <= (state_d inside {S_POLL, S_RD, S_CAP});
      addr      <= (state_d == S_POLL) ? ADDR_STAT : ADDR_DATA;
`endif

      // Counter restarts on every GAP entry; leaving GAP happens at GAP_LAST.
      if (state_q == S_GAP && state_d == S_GAP) gap_cnt <= gap_cnt + 8'd1;
      else                                      gap_cnt <= 8'd0;

      // The popped word is presented by the slave in the cycle after RD.
      if (state_q == S_CAP) gray_q <= rdata;

      err_flags <= err_flags | {enable & resp,
                                (state_q == S_POLL) & st_udf,
                                (state_q == S_POLL) & st_ovf};

      if (state_q == S_OUT && bin_ready) drained_cnt <= drained_cnt + 1'b1;
    end
  end

`ifndef GRAY2BIN_AUTOCLEAR_EN
  assign write = 1'b0;
  assign wdata = 8'h00;
`endif

endmodule

// File: tb/tb_gray2bin_drain.sv
// -----------------------------------------------------------------------------
// tb_gray2bin_drain
//
// Bench for gray2bin_drain with a small behavioural model of the register-
// mapped gray FIFO on the bus side and a scoreboard on the stream side.
// Expected binary words are computed by a prefix-XOR model when a gray word is
// loaded into the FIFO model and compared when the DUT hands a word off.
// -----------------------------------------------------------------------------
module tb_gray2bin_drain;

  localparam int POLL_GAP = 4;
  localparam int CNT_W    = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic             go;
  logic             enable;
  logic [1:0]       addr;
  logic             write;
  logic             read;
  logic [7:0]       wdata;
  logic [7:0]       rdata;
  logic             resp;
  logic [7:0]       bin_data;
  logic             bin_valid;
  logic             bin_ready;
  logic [2:0]       err_flags;
  logic [CNT_W-1:0] drained_cnt;
  logic [2:0]       state_dbg;

  gray2bin_drain #(.POLL_GAP(POLL_GAP), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .enable      (enable),
    .addr        (addr),
    .write       (write),
    .read        (read),
    .wdata       (wdata),
    .rdata       (rdata),
    .resp        (resp),
    .bin_data    (bin_data),
    .bin_valid   (bin_valid),
    .bin_ready   (bin_ready),
    .err_flags   (err_flags),
    .drained_cnt (drained_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- FIFO slave model ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] pop_reg;
  logic       fifo_empty;
  logic       stat_ovf;
  logic       stat_udf;
  logic       resp_on_cap;

  assign fifo_empty = (fifo_q.size() == 0);
  assign rdata = (addr == 2'd3) ? {4'b0000, stat_udf, stat_ovf, 1'b0, fifo_empty}
                                : pop_reg;
  // Error response only on the data-capture cycle (enable, no read, addr 0).
  assign resp = resp_on_cap & enable & ~read & (addr == 2'd0);

  always @(posedge clk) begin
    if (rst_n && enable && read && addr == 2'd0) begin
      if (fifo_q.size() != 0) pop_reg <= fifo_q.pop_front();
      else                    pop_reg <= 8'hEE;
    end
    if (rst_n && enable && write && addr == 2'd3 && wdata[4]) begin
      stat_ovf <= 1'b0;
      stat_udf <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int         acc_t[$];
  logic       held_valid;
  logic [7:0] held_data;
  logic       prev_write;
  int         bus_viol;
  int         wr_cycles;
  int         poll_after_wr;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_valid = 1'b0;
      prev_write = 1'b0;
    end else begin
      if (held_valid)
        check("stall_stable", 32'({bin_valid, bin_data}), 32'({1'b1, held_data}));
      if (bin_valid && bin_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 32'(bin_data), 32'h100);
        else check("word", 32'(bin_data), 32'(exp_q.pop_front()));
        acc_t.push_back(cyc);
      end
      held_valid = bin_valid & ~bin_ready;
      held_data  = bin_data;
      if (!write && wdata != 8'h00) bus_viol++;
      if ((read || write) && !enable) bus_viol++;
      if (read && write) bus_viol++;
      if (prev_write && enable && read && addr == 2'd3) poll_after_wr++;
      if (write) begin
        wr_cycles++;
        wr_addr = addr;
        wr_data = wdata;
      end
      prev_write = write;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    go = 1'b0;
    bin_ready = 1'b1;
    resp_on_cap = 1'b0;
    stat_ovf = 1'b0;
    stat_udf = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    acc_t.delete();
    wr_cycles = 0;
    poll_after_wr = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load(input logic [7:0] g, input bit expect_out);
    fifo_q.push_back(g);
    if (expect_out) exp_q.push_back(g2b(g));
  endtask

  task automatic set_go(input logic v);
    @(posedge clk); #1;
    go = v;
  endtask

  // which: 0 = poll start, 1 = bin_valid, 2 = FIFO pop (RD)
  task automatic wait_sig(input int which, output int t);
    bit hit;
    hit = 1'b0;
    t = -1;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = enable & read & (addr == 2'd3);
        1: hit = bin_valid;
        default: hit = enable & read & (addr == 2'd0);
      endcase
      if (hit) t = cyc;
    end
    if (!hit) check("wait_timeout", 32'(which), 32'hDEAD);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t0, t1, t2, t3, act;
    n_checks = 0;
    n_pass = 0;
    bus_viol = 0;
    cyc = 0;
    pop_reg = 8'h00;
    rst_n = 1'b1;
    go = 1'b0;
    bin_ready = 1'b1;
    resp_on_cap = 1'b0;
    stat_ovf = 1'b0;
    stat_udf = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_bus", 32'({enable, read, write, addr, wdata}), 32'd0);
    check("rst_valid", 32'(bin_valid), 32'd0);
    check("rst_flags", 32'(err_flags), 32'd0);
    check("rst_cnt", 32'(drained_cnt), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Single word 0x0F -> 0x0A, latency, then empty polling with gap
    load(8'h0F, 1'b1);
    set_go(1'b1);
    wait_sig(0, t0);
    wait_sig(1, t1);
    check("latency", 32'(t1 - t0), 32'd3);
    wait_sig(0, t2);
    check("out_to_poll", 32'(t2 - t1), 32'd1);
    @(negedge clk);
    check("gap_idle", 32'({state_dbg, enable}), 32'({3'd3, 1'b0}));
    wait_sig(0, t3);
    check("empty_poll_period", 32'(t3 - t2), 32'(POLL_GAP + 1));
    check("cnt_one", 32'(drained_cnt), 32'd1);
    check("sb_empty_1", 32'(exp_q.size()), 32'd0);

    // Three words with a stall on the first, then back-to-back
    do_reset();
    load(8'h80, 1'b1);
    load(8'h00, 1'b1);
    load(8'hC0, 1'b1);
    bin_ready = 1'b0;
    set_go(1'b1);
    wait_sig(1, t0);
    repeat (5) @(posedge clk);
    #1 bin_ready = 1'b1;
    wait_drain();
    check("cnt_three", 32'(drained_cnt), 32'd3);
    if (acc_t.size() == 3) begin
      check("throughput_2", 32'(acc_t[1] - acc_t[0]), 32'd4);
      check("throughput_3", 32'(acc_t[2] - acc_t[1]), 32'd4);
    end else begin
      check("accept_count", 32'(acc_t.size()), 32'd3);
    end

    // Overflow reported in status
    do_reset();
    stat_ovf = 1'b1;
    load(8'h0F, 1'b1);
    set_go(1'b1);
    wait_drain();
    check("ovf_flag", 32'(err_flags), 32'b001);
`ifdef GRAY2BIN_AUTOCLEAR_EN
    check("clr_cycles", 32'(wr_cycles), 32'd1);
    check("clr_addr", 32'(wr_addr), 32'd3);
    check("clr_wdata", 32'(wr_data), 32'h10);
    check("clr_repoll", 32'(poll_after_wr), 32'd1);
    check("clr_slave_ovf", 32'(stat_ovf), 32'd0);
`else
    check("no_write", 32'(wr_cycles), 32'd0);
`endif

    // Slave error response during capture
    do_reset();
    resp_on_cap = 1'b1;
    load(8'hC0, 1'b1);
    set_go(1'b1);
    wait_drain();
    check("resp_flag", 32'(err_flags), 32'b100);
    check("resp_cnt", 32'(drained_cnt), 32'd1);

    // go dropped during the pop
    do_reset();
    load(8'h0F, 1'b1);
    load(8'h80, 1'b0);
    set_go(1'b1);
    wait_sig(2, t0);
    go = 1'b0;
    @(negedge clk);
    check("drop_cap", 32'({enable, read, addr}), 32'({1'b1, 1'b0, 2'd0}));
    @(negedge clk);
    check("drop_out", 32'(bin_valid), 32'd1);
    @(negedge clk);
    check("drop_idle", 32'(state_dbg), 32'd0);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (enable || read || write) act++;
    end
    check("drop_no_bus", 32'(act), 32'd0);
    check("drop_fifo_left", 32'(fifo_q.size()), 32'd1);
    check("drop_cnt", 32'(drained_cnt), 32'd1);

    // Reset while a word waits in OUT
    do_reset();
    bin_ready = 1'b0;
    load(8'h80, 1'b1);
    set_go(1'b1);
    wait_sig(1, t0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bin_valid), 32'd0);
    check("rst_out_cnt", 32'(drained_cnt), 32'd0);
    check("rst_out_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    go = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("bus_rules", 32'(bus_viol), 32'd0);
    check("sb_final", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
